// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control token code words, decoded word record and
// the receive alignment FSM states.
package tmds_pkg;

  // Control tokens as they appear on the 10-bit channel word, bit 9 first
  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    WAIT   = 2'd2,
    LOCKED = 2'd3
  } tmds_state_e;

  // Result of decoding one 10-bit word
  typedef struct packed {
    logic       is_token;
    logic       c1;
    logic       c0;
    logic [7:0] data;
  } tmds_word_t;

endpackage

// File: rtl/tmds_word_dec.sv
// Combinational TMDS word decoder: classifies a 10-bit word as a control
// token (with its c1/c0 bits) or a data word (with its recovered byte).
module tmds_word_dec
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output tmds_word_t dec
);

  logic [7:0] d;

  // Undo the optional inversion, then undo the XOR/XNOR chain
  always_comb begin
    dec = '0;
    d   = word[9] ? ~word[7:0] : word[7:0];
    case (word)
      TOK_C00: begin dec.is_token = 1'b1; dec.c1 = 1'b0; dec.c0 = 1'b0; end
      TOK_C01: begin dec.is_token = 1'b1; dec.c1 = 1'b0; dec.c0 = 1'b1; end
      TOK_C10: begin dec.is_token = 1'b1; dec.c1 = 1'b1; dec.c0 = 1'b0; end
      TOK_C11: begin dec.is_token = 1'b1; dec.c1 = 1'b1; dec.c0 = 1'b1; end
      default: begin
        dec.data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
          dec.data[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
      end
    endcase
  end

endmodule

// File: rtl/tmds_decode.sv
// One TMDS channel receiver: registers the raw deserialized word, finds the
// word boundary by requesting bit-slips until control tokens line up, and
// presents the decoded byte / control bits two cycles after data_in.
//
// Output handshake: rgb_valid is a valid-only strobe with no back-pressure.
// In any cycle where rgb_valid is high, data_out carries one pixel byte that
// the sink must take in that cycle; when low, data_out is 0 and carries nothing.
module tmds_decode
  import tmds_pkg::*;
#(
  parameter int LOCK_TOKENS  = 8,
  parameter int SEARCH_WORDS = 4096,
  parameter int SLIP_WAIT    = 16,
  parameter int LOSS_WORDS   = 4096
)(
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [9:0] data_in,
  output logic [7:0] data_out,
  output logic       hsync,
  output logic       vsync,
  output logic       rgb_valid,
  output logic       bitslip,
  output logic       aligned,
  output logic [3:0] slip_cnt
);

  localparam int TOK_W  = (LOCK_TOKENS  > 1) ? $clog2(LOCK_TOKENS)  : 1;
  localparam int SRCH_W = (SEARCH_WORDS > 1) ? $clog2(SEARCH_WORDS) : 1;
  localparam int WAIT_W = (SLIP_WAIT    > 1) ? $clog2(SLIP_WAIT)    : 1;
  localparam int GAP_W  = (LOSS_WORDS   > 1) ? $clog2(LOSS_WORDS)   : 1;

  // Each counter is compared against its last value together with the
  // current word, so it never has to hold the limit itself.
  localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_TOKENS - 1);
  localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(LOSS_WORDS - 1);

  logic [9:0]        word_q;
  tmds_word_t        dec;
  tmds_state_e       state_q, state_d;
  logic [TOK_W-1:0]  tok_run_q, tok_run_d;
  logic [SRCH_W-1:0] word_cnt_q, word_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [3:0]        slip_cnt_d;
  logic              aligned_d;
  logic [7:0]        data_d;
  logic              hsync_d, vsync_d, valid_d;

  tmds_word_dec u_word_dec (
    .word (word_q),
    .dec  (dec)
  );

  // State register, counters and stage-1 word capture
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      word_q     <= '0;
      state_q    <= SEARCH;
      tok_run_q  <= '0;
      word_cnt_q <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      slip_cnt   <= '0;
    end else begin
      word_q     <= data_in;
      state_q    <= state_d;
      tok_run_q  <= tok_run_d;
      word_cnt_q <= word_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      slip_cnt   <= slip_cnt_d;
    end
  end

  // Alignment FSM next state: search for a token run, slip, settle, track lock
  always_comb begin
    state_d    = state_q;
    tok_run_d  = tok_run_q;
    word_cnt_d = word_cnt_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    slip_cnt_d = slip_cnt;
    case (state_q)
      SEARCH: begin
        word_cnt_d = word_cnt_q + 1'b1;
        tok_run_d  = dec.is_token ? tok_run_q + 1'b1 : '0;
        if (dec.is_token && (tok_run_q == TOK_LAST)) begin
          state_d    = LOCKED;
          slip_cnt_d = '0;
          gap_cnt_d  = '0;
          tok_run_d  = '0;
          word_cnt_d = '0;
        end else if (word_cnt_q == SRCH_LAST) begin
          state_d    = SLIP;
          tok_run_d  = '0;
          word_cnt_d = '0;
        end
      end
      SLIP: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
        slip_cnt_d = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 1'b1;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == WAIT_LAST) begin
          state_d    = SEARCH;
          wait_cnt_d = '0;
          tok_run_d  = '0;
          word_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (dec.is_token) begin
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d    = SEARCH;
          gap_cnt_d  = '0;
          tok_run_d  = '0;
          word_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Stage-2 output values, gated by the alignment the FSM is about to hold
  always_comb begin
    aligned_d = (state_d == LOCKED);
    data_d    = '0;
    valid_d   = 1'b0;
    hsync_d   = hsync;
    vsync_d   = vsync;
    if (!aligned_d) begin
      hsync_d = 1'b0;
      vsync_d = 1'b0;
    end else if (dec.is_token) begin
      hsync_d = dec.c0;
      vsync_d = dec.c1;
    end else begin
      valid_d = 1'b1;
      data_d  = dec.data;
    end
  end

  // Stage-2 output registers; bitslip is a registered decode of SLIP
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_out  <= '0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      rgb_valid <= 1'b0;
      aligned   <= 1'b0;
      bitslip   <= 1'b0;
    end else begin
      data_out  <= data_d;
      hsync     <= hsync_d;
      vsync     <= vsync_d;
      rgb_valid <= valid_d;
      aligned   <= aligned_d;
      bitslip   <= (state_d == SLIP);
    end
  end

endmodule

// File: tb/tb_tmds_decode.sv
// Bench for tmds_decode: directed TMDS words with hand-decoded expectations,
// a bit-slip deserializer model, lock/loss/relock and reset-in-WAIT cases.
module tb_tmds_decode;

  logic       vga_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [9:0] data_in   = '0;
  logic [7:0] data_out;
  logic       hsync, vsync, rgb_valid, bitslip, aligned;
  logic [3:0] slip_cnt;

  tmds_decode dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .data_in   (data_in),
    .data_out  (data_out),
    .hsync     (hsync),
    .vsync     (vsync),
    .rgb_valid (rgb_valid),
    .bitslip   (bitslip),
    .aligned   (aligned),
    .slip_cnt  (slip_cnt)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 vga_clk = ~vga_clk;

  int cycle = 0;
  always @(posedge vga_clk) cycle <= cycle + 1;

  // ---------------- scoreboard state ----------------
  // exp_q entry: {aligned, rgb_valid, vsync, hsync, data_out}
  logic [11:0] exp_q[$];
  int          due_q[$];
  int          slip_exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rot = 0;
  logic        bitslip_prev = 1'b0;
  logic [11:0] mon_e, mon_a;
  int          mon_c;

  // ---------------- driver tasks ----------------
  task automatic send(input logic [9:0] w, input logic [11:0] exp);
    @(posedge vga_clk); #1;
    data_in = w;
    exp_q.push_back(exp);
    due_q.push_back(cycle + 2);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({data_out, hsync, vsync, rgb_valid, bitslip, aligned, slip_cnt} !== 18'd0) begin
      errors++;
      $display("FAIL %s: outputs data=%h hs=%b vs=%b val=%b slip=%b al=%b cnt=%0d, required all 0",
               name, data_out, hsync, vsync, rgb_valid, bitslip, aligned, slip_cnt);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [19:0] t;
    t = {w, w} << n;
    return t[19:10];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge vga_clk) begin
    if (due_q.size() > 0 && due_q[0] <= cycle) begin
      mon_c = due_q.pop_front();
      mon_e = exp_q.pop_front();
      mon_a = {aligned, rgb_valid, vsync, hsync, data_out};
      checks++;
      if (mon_c != cycle || mon_a !== mon_e) begin
        errors++;
        $display("FAIL out_word @%0d (due %0d): got {al,val,vs,hs,data}=%h expected %h",
                 cycle, mon_c, mon_a, mon_e);
      end
    end
    if (bitslip === 1'b1) begin
      checks++;
      if (bitslip_prev === 1'b1) begin
        errors++;
        $display("FAIL bitslip_double @%0d: high on consecutive cycles, required single pulse", cycle);
      end else if (slip_exp_q.size() == 0) begin
        errors++;
        $display("FAIL bitslip_unexpected @%0d: got pulse, required none", cycle);
      end else begin
        mon_c = slip_exp_q.pop_front();
        if (mon_c != cycle) begin
          errors++;
          $display("FAIL bitslip_time: got pulse at %0d expected %0d", cycle, mon_c);
        end
      end
      if (rot > 0) rot = rot - 1;
    end
    bitslip_prev <= bitslip;
  end

  // ---------------- stimulus ----------------
  int  r, r2, r3, lock_cycle, prev_slip;
  bit  found;

  initial begin
    // Reset state
    repeat (2) @(posedge vga_clk);
    #1 check_reset_outputs("reset_state");
    sys_rst_n = 1'b1;

    // Lock on eight 00 tokens; only the 8th comes out aligned
    for (int i = 0; i < 7; i++) send(10'h354, 12'h000);
    send(10'h354, 12'h800);

    // Data and tokens while aligned
    send(10'h100, 12'hC00);
    send(10'h200, 12'hCFF);
    send(10'h0AB, 12'h900);
    send(10'h10F, 12'hD11);
    send(10'h154, 12'hA00);
    send(10'h2F0, 12'hEEF);
    send(10'h055, 12'hE01);
    send(10'h1AA, 12'hEFE);
    send(10'h0FF, 12'hEFF);
    send(10'h2AB, 12'hB00);

    // 4096 non-token words: lock drops on the last one
    for (int i = 0; i < 4095; i++) send(10'h100, 12'hF00);
    send(10'h100, 12'h000);

    // Relock
    for (int i = 0; i < 7; i++) send(10'h354, 12'h000);
    send(10'h354, 12'h800);
    send(10'h200, 12'hCFF);
    repeat (3) @(posedge vga_clk);

    // Async reset while locked, then a stream rotated by 3 bits
    #3 sys_rst_n = 1'b0;
    #1 check_reset_outputs("async_reset_locked");
    @(posedge vga_clk); #1;
    sys_rst_n = 1'b1;
    r = cycle;
    slip_exp_q.push_back(r + 4096);
    slip_exp_q.push_back(r + 8209);
    slip_exp_q.push_back(r + 12322);
    rot = 3;
    found = 1'b0;
    lock_cycle = 0;
    prev_slip = 0;
    for (int i = 0; i < 13000 && !found; i++) begin
      @(posedge vga_clk); #1;
      data_in = rotl(10'h354, rot);
      @(negedge vga_clk);
      if (aligned === 1'b1) begin
        found = 1'b1;
        lock_cycle = cycle;
      end else begin
        prev_slip = int'(slip_cnt);
      end
    end
    check_int("lock_found", int'(found), 1);
    check_int("lock_cycle", lock_cycle, r + 12347);
    check_int("slip_cnt_before_lock", prev_slip, 3);
    check_int("slip_cnt_after_lock", int'(slip_cnt), 0);
    check_int("slips_pending_after_lock", slip_exp_q.size(), 0);

    // Reset asserted during WAIT
    @(posedge vga_clk); #3;
    sys_rst_n = 1'b0;
    #1 check_reset_outputs("reset_before_wait_test");
    @(posedge vga_clk); #1;
    sys_rst_n = 1'b1;
    data_in = 10'h100;
    r2 = cycle;
    slip_exp_q.push_back(r2 + 4096);
    repeat (4100) @(posedge vga_clk);
    #1 check_int("slip_cnt_in_wait", int'(slip_cnt), 1);
    #2 sys_rst_n = 1'b0;
    #1 check_reset_outputs("reset_in_wait");
    @(posedge vga_clk); #1;
    sys_rst_n = 1'b1;
    r3 = cycle;
    slip_exp_q.push_back(r3 + 4096);
    repeat (4100) @(posedge vga_clk);
    #1 check_int("slips_pending_end", slip_exp_q.size(), 0);
    check_int("out_words_pending_end", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_decode.md
Name: tmds_decode

Overview:
Receive-side counterpart of the HDMI TMDS transmit path: one TMDS channel decoder at pixel rate.
- Input: raw 10-bit words from an external 1:10 deserializer.
- Aligns the word boundary by requesting bit-slips until control tokens appear.
- Recovers 8-bit pixel data, the two control bits (hsync/vsync on the blue channel) and data-enable.
- Three instances, one per colour channel, sit in the future hdmi_rx top between the deserializers and the video sink.

Parameters:
LOCK_TOKENS, 8, consecutive control tokens required to declare alignment
SEARCH_WORDS, 4096, words searched without lock before a bit-slip is requested
SLIP_WAIT, 16, cycles idled after a bit-slip for the deserializer to settle
LOSS_WORDS, 4096, words without any control token before lock is dropped

Ports:
vga_clk  in  1  pixel clock; all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
data_in  in  10  raw deserialized TMDS word, new word every cycle
data_out  out  8  decoded pixel byte
hsync  out  1  decoded control bit c0
vsync  out  1  decoded control bit c1
rgb_valid  out  1  data enable; high for data periods while aligned
bitslip  out  1  one-cycle pulse requesting a 1-bit shift of the deserializer
aligned  out  1  word alignment achieved
slip_cnt  out  4  bit-slips issued since last lock attempt, wraps 9->0

Behaviour:
- Reset: every output is 0 and the FSM is in SEARCH.
- Pipeline: data_in is registered (stage 1); decode result is registered into the outputs (stage 2). Latency is 2 cycles from data_in to data_out/hsync/vsync/rgb_valid.
- Control tokens, written as data_in[9:0]:
  - 10'b1101010100 -> c1c0=00
  - 10'b0010101011 -> 01
  - 10'b0101010100 -> 10
  - 10'b1010101011 -> 11
- Data decode (any non-token word):
  - d = data_in[9] ? ~data_in[7:0] : data_in[7:0]
  - out[0] = d[0]
  - out[i] = data_in[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]) for i = 1..7
- Output rules while aligned:
  - Token word: rgb_valid=0, data_out=0, hsync/vsync take c0/c1.
  - Data word: rgb_valid=1, data_out=decoded byte, hsync/vsync hold their last values.
- Output rules while not aligned: rgb_valid=0, data_out=0, hsync=0, vsync=0.
- FSM, driven by the stage-1 word:
  - SEARCH:
    - tok_run counts consecutive token words (any of the four) and resets on a non-token word.
    - word_cnt counts words.
    - tok_run==LOCK_TOKENS -> LOCKED, aligned=1, slip_cnt cleared.
    - Else word_cnt==SEARCH_WORDS-1 -> SLIP.
    - Lock takes priority if both conditions occur on the same cycle.
  - SLIP: bitslip=1 for exactly one cycle; slip_cnt increments (9 wraps to 0) -> WAIT.
  - WAIT: counts SLIP_WAIT cycles, ignoring data_in -> SEARCH with tok_run and word_cnt cleared.
  - LOCKED:
    - gap_cnt resets on every token word and saturates at LOSS_WORDS.
    - gap_cnt reaching LOSS_WORDS -> SEARCH: aligned=0 from the next cycle, counters cleared.
- bitslip is asserted only in SLIP; it is never high on two consecutive cycles.
- Reset asserted mid-operation: immediate return to reset values, with no bitslip glitch.
- All counters are sized with $clog2 of their limit and never overflow.

Decomposition:
- Package tmds_pkg:
  - the four 10-bit token constants (shared with the transmit encode block);
  - FSM state enum SEARCH/SLIP/WAIT/LOCKED.
- Sub-module tmds_word_dec: purely combinational 10b -> {is_token, c1, c0, byte}. It is instantiated inside tmds_decode; the FSM and pipeline stay in the top.

Test Plan:
- Reset, then 10'h354 (token 00) repeated 8 times -> aligned=1 on the cycle after the 8th word is registered; hsync=0, vsync=0, bitslip never pulses.
- After lock, data_in=10'h100 then 10'h200 -> two cycles later data_out=8'h00 then 8'hFF with rgb_valid=1; hsync/vsync hold their last token values.
- After lock, token 10'hAB (c1c0=01) -> hsync=1, vsync=0, rgb_valid=0, data_out=0, at latency 2.
- Token stream rotated by 3 bits, with the bench model rotating back 1 bit per bitslip pulse -> bitslip pulses at word 4095 of each search, with 16-cycle gaps; lock follows the 3rd slip; slip_cnt was 3 just before lock clears it.
- Locked, then 4096 non-token words -> aligned falls, rgb_valid=0, SEARCH resumes; reinjecting 8 tokens relocks.
- sys_rst_n pulsed low during WAIT -> all outputs 0 asynchronously; after release bitslip stays low until a full SEARCH_WORDS window expires.
